// File: rtl/sfifo_wr_arbiter.sv
// sfifo_wr_arbiter: round-robin write arbiter sharing one adder-output sfifo
// between NUM_REQ producer lanes. The granted lane's word is tagged with its
// lane index and written to the FIFO. Pops are snooped to return credits, and
// a flush FSM drains the FIFO on request.
// Optional feature: define ARB_CREDIT_EN to enable per-lane credit counters.

`ifndef DATA_WIDTH_ADD_STG
`define DATA_WIDTH_ADD_STG 32
`endif

module sfifo_wr_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DSIZE    = `DATA_WIDTH_ADD_STG,
    parameter int unsigned MAX_CRED = 4,
    localparam int unsigned TAGW    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*DSIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     fifo_wr_en,
    output logic [TAGW+DSIZE-1:0]    fifo_data_in,
    input  logic                     fifo_full,
    input  logic                     fifo_empty,
    input  logic                     fifo_rd_en,
    input  logic [TAGW+DSIZE-1:0]    fifo_data_out,
    input  logic                     flush_req,
    output logic                     flush_done,
    output logic                     busy
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [TAGW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] cred_ok;
    logic [NUM_REQ-1:0] eligible;
    logic              run_ok;
    logic              grant_found;
    logic [TAGW-1:0]   grant_idx;
    int unsigned       lane;

    // Lane eligibility: only in RUN, no pending flush, FIFO not full, credit left
    always_comb begin
        run_ok   = (state_q == ST_RUN) && !flush_req && !fifo_full && !rst;
        eligible = req_valid & cred_ok & {NUM_REQ{run_ok}};
    end

    // Round-robin search: first eligible lane at or after rr_ptr, wrapping
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        lane        = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            lane = (32'(rr_ptr_q) + k) % NUM_REQ;
            if (!grant_found && eligible[lane]) begin
                grant_found = 1'b1;
                grant_idx   = lane[TAGW-1:0];
            end
        end
    end

    // Grant, tagged write data and next pointer
    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = grant_found;
        fifo_data_in = '0;
        rr_ptr_d     = rr_ptr_q;
        if (grant_found) begin
            req_ready[grant_idx] = 1'b1;
            fifo_data_in = {grant_idx, req_data[32'(grant_idx)*DSIZE +: DSIZE]};
            if (32'(grant_idx) == NUM_REQ - 1)
                rr_ptr_d = '0;
            else
                rr_ptr_d = grant_idx + TAGW'(1);
        end
    end

    // Flush FSM next state and done pulse
    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (flush_req)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                flush_done = !rst;
                state_d    = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign busy = (state_q != ST_RUN) || (|req_valid);

    // State and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef ARB_CREDIT_EN
    localparam int unsigned CW = $clog2(MAX_CRED + 1);

    logic [CW-1:0]      credit_q [NUM_REQ];
    logic [CW-1:0]      credit_d [NUM_REQ];
    logic               pop;
    logic [TAGW-1:0]    pop_tag;
    logic [NUM_REQ-1:0] pop_hit;
    logic               unused_payload;

    assign pop            = fifo_rd_en && !fifo_empty;
    assign pop_tag        = fifo_data_out[TAGW+DSIZE-1 -: TAGW];
    assign unused_payload = ^fifo_data_out[DSIZE-1:0];

    // Per-lane pop decode and credit availability
    always_comb begin
        pop_hit = '0;
        cred_ok = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pop_hit[i] = pop && (32'(pop_tag) == i);
            cred_ok[i] = (credit_q[i] != '0);
        end
    end

    // Credit update: grant consumes, pop returns, both cancel; DONE reloads
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            credit_d[i] = credit_q[i];
            if (state_q == ST_DONE)
                credit_d[i] = CW'(MAX_CRED);
            else if (req_ready[i] && !pop_hit[i])
                credit_d[i] = credit_q[i] - 1'b1;
            else if (pop_hit[i] && !req_ready[i] && (credit_q[i] != CW'(MAX_CRED)))
                credit_d[i] = credit_q[i] + 1'b1;
        end
    end

    // Credit registers
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (rst)
                credit_q[i] <= CW'(MAX_CRED);
            else
                credit_q[i] <= credit_d[i];
        end
    end
`else
    logic unused_snoop;

    assign cred_ok      = '1;
    assign unused_snoop = ^{fifo_rd_en, fifo_data_out, MAX_CRED};
`endif

endmodule

// File: tb/tb_sfifo_wr_arbiter.sv
// Scoreboard bench for sfifo_wr_arbiter with an environment FIFO and a
// behavioural reference model of the arbitration, credit and flush rules.
module tb_sfifo_wr_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned TW    = 2;
    localparam int unsigned W     = TW + DW;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned MAXC  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              fifo_wr_en;
    logic [W-1:0]      fifo_data_in;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [W-1:0]      fifo_data_out;
    logic              flush_req;
    logic              flush_done;
    logic              busy;

    always #5 clk = ~clk;

    sfifo_wr_arbiter #(
        .NUM_REQ (N),
        .DSIZE   (DW),
        .MAX_CRED(MAXC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_data_out(fifo_data_out),
        .flush_req    (flush_req),
        .flush_done   (flush_done),
        .busy         (busy)
    );

    typedef struct packed {
        logic [N-1:0] ready;
        logic         wr_en;
        logic [W-1:0] data;
        logic         done;
        logic         busy;
    } exp_t;

    exp_t        exp_q[$];
    logic [W-1:0] fifo_m[$];

    // Reference model state: next lane to favour, flush phase, credits
    int unsigned m_ptr = 0;
    bit          m_draining = 0;
    bit          m_done_next = 0;
    int unsigned m_cred[N];

    int vectors = 0;
    int miscompares = 0;

    task automatic cycle(input bit r, input logic [N-1:0] v, input bit rd,
                         input bit fl, input bit stall);
        exp_t        e;
        int          g;
        bit          popv;
        int unsigned ptag;
        bit          in_run;
        @(posedge clk);
        #1;
        rst        = r;
        req_valid  = v;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
        fifo_rd_en = rd;
        flush_req  = fl;
        fifo_full  = stall || (fifo_m.size() >= DEPTH);
        fifo_empty = (fifo_m.size() == 0);
        fifo_data_out = fifo_empty ? '0 : fifo_m[0];

        in_run = !m_draining && !m_done_next;
        popv   = rd && (fifo_m.size() != 0);
        ptag   = popv ? 32'(fifo_m[0][W-1 -: TW]) : 0;

        e      = '0;
        e.busy = !in_run || (|v);
        g      = -1;
        if (!r) begin
            for (int k = 0; k < N; k++) begin
                int lane;
                bit has_credit;
                lane = (m_ptr + k) % N;
                has_credit = 1'b1;
`ifdef ARB_CREDIT_EN
                has_credit = (m_cred[lane] != 0);
`endif
                if (g < 0 && v[lane] && in_run && !fl && !fifo_full && has_credit)
                    g = lane;
            end
            if (g >= 0) begin
                e.ready[g] = 1'b1;
                e.wr_en    = 1'b1;
                e.data     = {TW'(g), req_data[g*DW +: DW]};
            end
            e.done = m_done_next;
        end
        exp_q.push_back(e);

        if (r) begin
            m_ptr = 0;
            m_draining = 0;
            m_done_next = 0;
            for (int i = 0; i < N; i++) m_cred[i] = MAXC;
        end else begin
            if (g >= 0) m_ptr = (g + 1) % N;
            if (m_done_next) begin
                for (int i = 0; i < N; i++) m_cred[i] = MAXC;
            end else begin
                if (g >= 0 && !(popv && int'(ptag) == g)) m_cred[g]--;
                if (popv && ptag < N && !(g >= 0 && int'(ptag) == g) && m_cred[ptag] < MAXC)
                    m_cred[ptag]++;
            end
            if (m_done_next) begin
                m_done_next = 0;
            end else if (m_draining) begin
                if (fifo_m.size() == 0) begin
                    m_draining = 0;
                    m_done_next = 1;
                end
            end else if (fl) begin
                m_draining = 1;
            end
        end

        if (popv) void'(fifo_m.pop_front());
        if (g >= 0) fifo_m.push_back(e.data);
    endtask

    // Monitor: compare every presented cycle against the scoreboard head
    initial begin
        exp_t e;
        exp_t act;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                act = {req_ready, fifo_wr_en, fifo_data_in, flush_done, busy};
                vectors++;
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL vec%0d t=%0t: got ready=%b wr=%b data=%h done=%b busy=%b, expected ready=%b wr=%b data=%h done=%b busy=%b",
                             vectors, $time, act.ready, act.wr_en, act.data, act.done, act.busy,
                             e.ready, e.wr_en, e.data, e.done, e.busy);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0;
        fifo_empty = 1'b1; fifo_rd_en = 1'b0; fifo_data_out = '0; flush_req = 1'b0;
        for (int i = 0; i < N; i++) m_cred[i] = MAXC;

        // Reset, then all lanes requesting with a consumer popping every cycle
        repeat (2) cycle(1, 4'hF, 1, 0, 0);
        repeat (8) cycle(0, 4'hF, 1, 0, 0);

        // Only lanes 1 and 3 requesting from rr_ptr=0
        cycle(1, 4'b1010, 1, 0, 0);
        repeat (6) cycle(0, 4'b1010, 1, 0, 0);

        // Full stall for three cycles, then resume
        cycle(0, 4'hF, 1, 0, 0);
        repeat (3) cycle(0, 4'hF, 1, 0, 1);
        repeat (3) cycle(0, 4'hF, 1, 0, 0);

        // Fill three entries, pulse flush, drain with consumer popping
        cycle(1, 4'h0, 1, 0, 0);
        repeat (3) cycle(0, 4'h1, 0, 0, 0);
        cycle(0, 4'hF, 1, 1, 0);
        repeat (8) cycle(0, 4'hF, 1, 0, 0);

        // Reset in the middle of a drain
        repeat (2) cycle(0, 4'hF, 0, 0, 0);
        cycle(0, 4'hF, 0, 1, 0);
        cycle(0, 4'hF, 0, 0, 0);
        cycle(1, 4'hF, 0, 0, 0);
        repeat (6) cycle(0, 4'hF, 1, 0, 0);

        // Single lane exhausting its credits, then one returned by a pop
        cycle(1, 4'h0, 1, 0, 0);
        repeat (4) cycle(0, 4'b0100, 1, 0, 0);
        cycle(1, 4'h0, 0, 0, 0);
        repeat (4) cycle(0, 4'b0100, 0, 0, 0);
        cycle(0, 4'b0100, 1, 0, 0);
        repeat (3) cycle(0, 4'b0100, 0, 0, 0);
        repeat (12) cycle(0, 4'h0, 1, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 199) == 0, N'($urandom), $urandom_range(0, 9) < 7,
                  $urandom_range(0, 49) == 0, $urandom_range(0, 15) == 0);
        end

        repeat (2) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
